// File: rtl/y86_fetch_stage.sv
// y86_fetch_stage
//   Pipelined Y86-64 fetch stage. It selects the fetch PC (return address,
//   then mispredict correction, then predicted PC) and decodes the 10
//   instruction bytes into icode/ifun/rA/rB/valC/valP. It predicts the next
//   PC and loads the F/D pipeline register that feeds decode.
//
// Ports
//   clk, rst                   clock; synchronous active-high reset
//   imem_addr                  fetch PC, combinational from PC select
//   imem_bytes, imem_error     instruction bytes (byte 0 at [7:0]) and
//                              invalid-address flag for imem_addr
//   F_stall                    hold predPC
//   D_stall, D_bubble          hold / load nop into the F/D register
//   redirect_valid/_pc         branch-mispredict correction
//   ret_valid/_pc              return address from write-back
//   D_*                        F/D register contents
//   f_halted                   fetch frozen after a non-AOK instruction
//
// Parameters
//   RESET_PC                   predPC value after reset
//
// Build option
//   Y86_BTFNT_EN               when defined, conditional jumps are predicted
//                              taken only when the target is backward
//                              (valC < valP); otherwise every jXX is taken.

module y86_fetch_stage #(
    parameter logic [63:0] RESET_PC = 64'h0
) (
    input  logic        clk,
    input  logic        rst,
    output logic [63:0] imem_addr,
    input  logic [79:0] imem_bytes,
    input  logic        imem_error,
    input  logic        F_stall,
    input  logic        D_stall,
    input  logic        D_bubble,
    input  logic        redirect_valid,
    input  logic [63:0] redirect_pc,
    input  logic        ret_valid,
    input  logic [63:0] ret_pc,
    output logic [2:0]  D_stat,
    output logic [3:0]  D_icode,
    output logic [3:0]  D_ifun,
    output logic [3:0]  D_rA,
    output logic [3:0]  D_rB,
    output logic [63:0] D_valC,
    output logic [63:0] D_valP,
    output logic        D_pred_taken,
    output logic        f_halted
);

    typedef enum logic [3:0] {
        I_HALT   = 4'h0,
        I_NOP    = 4'h1,
        I_RRMOVQ = 4'h2,
        I_IRMOVQ = 4'h3,
        I_RMMOVQ = 4'h4,
        I_MRMOVQ = 4'h5,
        I_OPQ    = 4'h6,
        I_JXX    = 4'h7,
        I_CALL   = 4'h8,
        I_RET    = 4'h9,
        I_PUSHQ  = 4'hA,
        I_POPQ   = 4'hB
    } icode_e;

    typedef enum logic [2:0] {
        STAT_AOK = 3'd1,
        STAT_HLT = 3'd2,
        STAT_ADR = 3'd3,
        STAT_INS = 3'd4
    } stat_e;

    typedef enum logic {
        FETCH_RUN,
        FETCH_HALTED
    } fetch_state_e;

    typedef struct packed {
        logic [2:0]  stat;
        logic [3:0]  icode;
        logic [3:0]  ifun;
        logic [3:0]  rA;
        logic [3:0]  rB;
        logic [63:0] valC;
        logic [63:0] valP;
        logic        pred_taken;
    } fd_t;

    localparam fd_t FD_BUBBLE = '{
        stat:       STAT_AOK,
        icode:      I_NOP,
        ifun:       4'h0,
        rA:         4'hF,
        rB:         4'hF,
        valC:       64'h0,
        valP:       64'h0,
        pred_taken: 1'b0
    };

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    fetch_state_e state_q, state_d;
    logic [63:0]  pred_pc_q, pred_pc_d;
    fd_t          fd_q, fd_d;

    // ------------------------------------------------------------------
    // PC select
    // ------------------------------------------------------------------
    logic        redirect_any;
    logic [63:0] f_pc;

    always_comb begin
        redirect_any = ret_valid | redirect_valid;
        if (ret_valid) begin
            f_pc = ret_pc;
        end else if (redirect_valid) begin
            f_pc = redirect_pc;
        end else begin
            f_pc = pred_pc_q;
        end
    end

    assign imem_addr = f_pc;

    // ------------------------------------------------------------------
    // Decode
    // ------------------------------------------------------------------
    logic [3:0]  f_icode;
    logic [3:0]  f_ifun;
    logic        need_regids;
    logic        need_valc;
    logic        instr_valid;
    logic [3:0]  f_rA;
    logic [3:0]  f_rB;
    logic [63:0] f_valC;
    logic [63:0] f_valP;
    stat_e       f_stat;

    always_comb begin
        // A bad fetch address replaces the instruction with a nop so that
        // nothing downstream acts on garbage bytes.
        if (imem_error) begin
            f_icode = I_NOP;
            f_ifun  = 4'h0;
        end else begin
            f_icode = imem_bytes[7:4];
            f_ifun  = imem_bytes[3:0];
        end

        case (f_icode)
            I_RRMOVQ, I_IRMOVQ, I_RMMOVQ, I_MRMOVQ,
            I_OPQ, I_PUSHQ, I_POPQ: need_regids = 1'b1;
            default:                need_regids = 1'b0;
        endcase

        case (f_icode)
            I_IRMOVQ, I_RMMOVQ, I_MRMOVQ,
            I_JXX, I_CALL:          need_valc = 1'b1;
            default:                need_valc = 1'b0;
        endcase

        instr_valid = (f_icode <= I_POPQ);

        if (need_regids) begin
            f_rA = imem_bytes[15:12];
            f_rB = imem_bytes[11:8];
        end else begin
            f_rA = 4'hF;
            f_rB = 4'hF;
        end

        // The constant word starts right after the register byte when one
        // is present, otherwise right after the opcode byte.
        if (!need_valc) begin
            f_valC = '0;
        end else if (need_regids) begin
            f_valC = imem_bytes[79:16];
        end else begin
            f_valC = imem_bytes[71:8];
        end

        f_valP = f_pc + 64'd1 + 64'(need_regids) + (need_valc ? 64'd8 : 64'd0);

        if (imem_error) begin
            f_stat = STAT_ADR;
        end else if (!instr_valid) begin
            f_stat = STAT_INS;
        end else if (f_icode == I_HALT) begin
            f_stat = STAT_HLT;
        end else begin
            f_stat = STAT_AOK;
        end
    end

    // ------------------------------------------------------------------
    // Next-PC prediction
    // ------------------------------------------------------------------
    logic        f_pred_taken;
    logic [63:0] f_pred_pc;

    always_comb begin
        f_pred_taken = 1'b0;
        if (f_icode == I_CALL) begin
            f_pred_taken = 1'b1;
        end else if (f_icode == I_JXX) begin
`ifdef Y86_BTFNT_EN
            // Unconditional jmp is always taken; conditional jumps only
            // when jumping backward (loop-closing branches).
            f_pred_taken = (f_ifun == 4'h0) || (f_valC < f_valP);
`else
            f_pred_taken = 1'b1;
`endif
        end
        f_pred_pc = f_pred_taken ? f_valC : f_valP;
    end

    fd_t f_fd;

    always_comb begin
        f_fd            = FD_BUBBLE;
        f_fd.stat       = f_stat;
        f_fd.icode      = f_icode;
        f_fd.ifun       = f_ifun;
        f_fd.rA         = f_rA;
        f_fd.rB         = f_rB;
        f_fd.valC       = f_valC;
        f_fd.valP       = f_valP;
        f_fd.pred_taken = f_pred_taken;
    end

    // ------------------------------------------------------------------
    // Halt FSM, predPC and F/D register control
    // ------------------------------------------------------------------
    logic halted_now;
    logic load_fetched;

    always_comb begin
        state_d   = state_q;
        pred_pc_d = pred_pc_q;
        fd_d      = fd_q;

        // A redirect or return releases the halt in the same cycle, so the
        // redirected instruction is fetched and loaded normally.
        halted_now   = (state_q == FETCH_HALTED) && !redirect_any;
        load_fetched = !D_stall && !D_bubble && !halted_now;

        if (redirect_any || (!F_stall && state_q == FETCH_RUN)) begin
            pred_pc_d = f_pred_pc;
        end

        if (!D_stall) begin
            fd_d = load_fetched ? f_fd : FD_BUBBLE;
        end

        if (load_fetched && f_stat != STAT_AOK) begin
            state_d = FETCH_HALTED;
        end else if (redirect_any) begin
            state_d = FETCH_RUN;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= FETCH_RUN;
            pred_pc_q <= RESET_PC;
            fd_q      <= FD_BUBBLE;
        end else begin
            state_q   <= state_d;
            pred_pc_q <= pred_pc_d;
            fd_q      <= fd_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign D_stat       = fd_q.stat;
    assign D_icode      = fd_q.icode;
    assign D_ifun       = fd_q.ifun;
    assign D_rA         = fd_q.rA;
    assign D_rB         = fd_q.rB;
    assign D_valC       = fd_q.valC;
    assign D_valP       = fd_q.valP;
    assign D_pred_taken = fd_q.pred_taken;
    assign f_halted     = (state_q == FETCH_HALTED);

endmodule
